// File: rtl/potato1_pkg.sv
// Shared definitions for the potato1 core and datapath: command bits, opcodes, default sizes.
package potato1_pkg;

  localparam int CMD_PC_INC = 0;
  localparam int CMD_PC_DEC = 1;
  localparam int CMD_X_INC  = 2;
  localparam int CMD_X_DEC  = 3;
  localparam int CMD_A_INC  = 4;
  localparam int CMD_A_DEC  = 5;
  localparam int CMD_PUT    = 6;
  localparam int CMD_GET    = 7;

  localparam int PC_W_DEF       = 8;
  localparam int TAPE_DEPTH_DEF = 16;
  localparam int CELL_W_DEF     = 8;

  typedef enum logic [3:0] {
    OP_X_INC = 4'b0000,
    OP_X_DEC = 4'b0001,
    OP_A_INC = 4'b0010,
    OP_A_DEC = 4'b0011,
    OP_PUT   = 4'b0100,
    OP_GET   = 4'b0101,
    OP_JZ    = 4'b0110,
    OP_JNZ   = 4'b0111,
    OP_HALT  = 4'b1111
  } opcode_e;

  // A word carrying a PC move is the first issue of an instruction.
  function automatic logic is_fresh(input logic [7:0] cmd);
    return cmd[CMD_PC_INC] | cmd[CMD_PC_DEC];
  endfunction

endpackage

// File: rtl/potato1_tape.sv
// Data tape: cell registers with one inc/dec/write port at X, read port and zero detect at X.
module potato1_tape
  import potato1_pkg::*;
#(
  parameter int DEPTH  = TAPE_DEPTH_DEF,
  parameter int CELL_W = CELL_W_DEF,
  parameter int X_W    = $clog2(TAPE_DEPTH_DEF)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [X_W-1:0]    x_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              wr_en_i,
  input  logic [CELL_W-1:0] wr_data_i,
  output logic [CELL_W-1:0] rd_data_o,
  output logic              zero_o
);

  logic [CELL_W-1:0] cells_q [DEPTH];
  logic [CELL_W-1:0] cell_d;
  logic              cell_we;

  assign rd_data_o = cells_q[x_i];
  assign zero_o    = (rd_data_o == '0);

  // An external write wins over any arithmetic on the same cell.
  always_comb begin
    cell_d  = rd_data_o;
    cell_we = 1'b0;
    if (wr_en_i) begin
      cell_d  = wr_data_i;
      cell_we = 1'b1;
    end else if (inc_i && !dec_i) begin
      cell_d  = rd_data_o + CELL_W'(1);
      cell_we = 1'b1;
    end else if (dec_i && !inc_i) begin
      cell_d  = rd_data_o - CELL_W'(1);
      cell_we = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
          cells_q[gi] <= '0;
        end else if (cell_we && (x_i == X_W'(gi))) begin
          cells_q[gi] <= cell_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/potato1_datapath.sv
// potato1 datapath: program counter, data pointer, tape and the PUT/GET handshake tracker.
module potato1_datapath
  import potato1_pkg::*;
#(
  parameter  int PC_W       = PC_W_DEF,
  parameter  int TAPE_DEPTH = TAPE_DEPTH_DEF,
  parameter  int CELL_W     = CELL_W_DEF,
  localparam int X_W        = $clog2(TAPE_DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [7:0]        Command,
  output logic [PC_W-1:0]   ProgAddr,
  input  logic [3:0]        ProgData,
  output logic [3:0]        Instr,
  output logic              Zero,
  output logic              IoBusy,
  output logic [X_W-1:0]    DataPtr,
  output logic [CELL_W-1:0] PutData,
  output logic              PutValid,
  input  logic              PutReady,
  input  logic [CELL_W-1:0] GetData,
  input  logic              GetValid,
  output logic              GetReady
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [X_W-1:0]  x_q, x_d;
  logic            io_done_q, io_done_d;
  logic            fresh, pending, get_xfer, put_xfer;

  assign fresh    = is_fresh(Command);
  // A repeated (non-fresh) word only re-offers the transfer if it has not happened yet.
  assign pending  = fresh | ~io_done_q;
  assign GetReady = Command[CMD_GET] & pending;
  assign PutValid = Command[CMD_PUT] & ~Command[CMD_GET] & pending;
  assign IoBusy   = PutValid | GetReady;
  assign get_xfer = GetValid & GetReady;
  assign put_xfer = PutValid & PutReady;

  assign Instr    = ProgData;
  assign ProgAddr = pc_q;
  assign DataPtr  = x_q;

  always_comb begin
    pc_d = pc_q;
    if (Command[CMD_PC_INC] && !Command[CMD_PC_DEC]) pc_d = pc_q + PC_W'(1);
    if (Command[CMD_PC_DEC] && !Command[CMD_PC_INC]) pc_d = pc_q - PC_W'(1);
  end

  always_comb begin
    x_d = x_q;
    if (Command[CMD_X_INC] && !Command[CMD_X_DEC])
      x_d = (x_q == X_W'(TAPE_DEPTH - 1)) ? '0 : x_q + X_W'(1);
    if (Command[CMD_X_DEC] && !Command[CMD_X_INC])
      x_d = (x_q == '0) ? X_W'(TAPE_DEPTH - 1) : x_q - X_W'(1);
  end

  always_comb begin
    io_done_d = io_done_q;
    if (put_xfer || get_xfer) io_done_d = 1'b1;
    else if (fresh)           io_done_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= '0;
      x_q       <= '0;
      io_done_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      x_q       <= x_d;
      io_done_q <= io_done_d;
    end
  end

  potato1_tape #(
    .DEPTH (TAPE_DEPTH),
    .CELL_W(CELL_W),
    .X_W   (X_W)
  ) u_tape (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .x_i      (x_q),
    .inc_i    (Command[CMD_A_INC]),
    .dec_i    (Command[CMD_A_DEC]),
    .wr_en_i  (get_xfer),
    .wr_data_i(GetData),
    .rd_data_o(PutData),
    .zero_o   (Zero)
  );

endmodule

// File: tb/tb_potato1_datapath.sv
// Directed, table-driven bench for potato1_datapath with hand-computed expectations.
module tb_potato1_datapath;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [7:0] Command;
  logic [7:0] ProgAddr;
  logic [3:0] ProgData;
  logic [3:0] Instr;
  logic       Zero, IoBusy;
  logic [3:0] DataPtr;
  logic [7:0] PutData;
  logic       PutValid, PutReady;
  logic [7:0] GetData;
  logic       GetValid, GetReady;

  int total_checks = 0;
  int passed_checks = 0;
  int put_xfers = 0;

  always #5 Clock = ~Clock;

  potato1_datapath dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Command (Command),
    .ProgAddr(ProgAddr),
    .ProgData(ProgData),
    .Instr   (Instr),
    .Zero    (Zero),
    .IoBusy  (IoBusy),
    .DataPtr (DataPtr),
    .PutData (PutData),
    .PutValid(PutValid),
    .PutReady(PutReady),
    .GetData (GetData),
    .GetValid(GetValid),
    .GetReady(GetReady)
  );

  typedef struct {
    logic [7:0] cmd;
    logic       pr;
    logic       gv;
    logic [7:0] gd;
    logic       pv;     // expected before the edge
    logic       gr;
    logic       busy;
    logic [7:0] pdata;
    logic [7:0] pc;     // expected after the edge
    logic [3:0] x;
    logic       zero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] cmd, input logic pr, input logic gv, input logic [7:0] gd,
                     input logic pv, input logic gr, input logic busy, input logic [7:0] pdata,
                     input logic [7:0] pc, input logic [3:0] x, input logic zero);
    vec_t v;
    v.cmd = cmd; v.pr = pr; v.gv = gv; v.gd = gd;
    v.pv = pv; v.gr = gr; v.busy = busy; v.pdata = pdata;
    v.pc = pc; v.x = x; v.zero = zero;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [3:0] pd;
    @(negedge Clock);
    Command  = v.cmd;
    PutReady = v.pr;
    GetValid = v.gv;
    GetData  = v.gd;
    pd       = v.cmd[3:0] ^ 4'hA;
    ProgData = pd;
    #4;
    chk($sformatf("v%0d_putvalid", idx), 32'(PutValid), 32'(v.pv));
    chk($sformatf("v%0d_getready", idx), 32'(GetReady), 32'(v.gr));
    chk($sformatf("v%0d_iobusy", idx), 32'(IoBusy), 32'(v.busy));
    chk($sformatf("v%0d_putdata", idx), 32'(PutData), 32'(v.pdata));
    chk($sformatf("v%0d_instr", idx), 32'(Instr), 32'(pd));
    if (PutValid && PutReady) put_xfers++;
    @(posedge Clock);
    #1;
    chk($sformatf("v%0d_progaddr", idx), 32'(ProgAddr), 32'(v.pc));
    chk($sformatf("v%0d_dataptr", idx), 32'(DataPtr), 32'(v.x));
    chk($sformatf("v%0d_zero", idx), 32'(Zero), 32'(v.zero));
    $display("vec %0d cmd=%02h pa=%02h x=%0d pd=%02h z=%0b busy=%0b", idx, v.cmd, ProgAddr,
             DataPtr, PutData, Zero, IoBusy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_progaddr"}, 32'(ProgAddr), 32'h0);
    chk({tag, "_dataptr"}, 32'(DataPtr), 32'h0);
    chk({tag, "_zero"}, 32'(Zero), 32'h1);
    chk({tag, "_putdata"}, 32'(PutData), 32'h0);
    chk({tag, "_putvalid"}, 32'(PutValid), 32'h0);
    chk({tag, "_getready"}, 32'(GetReady), 32'h0);
    chk({tag, "_iobusy"}, 32'(IoBusy), 32'h0);
  endtask

  initial begin
    Reset_n = 1'b0; Command = 8'h00; ProgData = 4'h0;
    PutReady = 1'b0; GetValid = 1'b0; GetData = 8'h00;

    //  cmd   pr gv gd     pv gr bz pdata  pc     x   z
    add(8'h01, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 0,  1);
    add(8'h01, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02, 0,  1);
    add(8'h01, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h03, 0,  1);
    add(8'h03, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h03, 0,  1);
    add(8'h02, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02, 0,  1);
    add(8'h02, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 0,  1);
    add(8'h02, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  1);
    add(8'h02, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF, 0,  1);
    add(8'h01, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  1);
    add(8'h10, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  0);
    add(8'h10, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0,  0);
    add(8'h10, 0, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0,  0);
    add(8'h20, 0, 0, 8'h00, 0, 0, 0, 8'h03, 8'h00, 0,  0);
    add(8'h20, 0, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0,  0);
    add(8'h20, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0,  1);
    add(8'h20, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  0);
    add(8'h30, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'h00, 0,  0);
    add(8'h08, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'h00, 15, 1);
    add(8'h04, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  0);
    add(8'h14, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'h00, 1,  1);
    add(8'h0C, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1);
    add(8'h08, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  1);
    add(8'h81, 0, 1, 8'h41, 0, 1, 1, 8'h00, 8'h01, 0,  0);
    add(8'h80, 0, 1, 8'h55, 0, 0, 0, 8'h41, 8'h01, 0,  0);
    add(8'h41, 0, 0, 8'h00, 1, 0, 1, 8'h41, 8'h02, 0,  0);
    add(8'h40, 0, 0, 8'h00, 1, 0, 1, 8'h41, 8'h02, 0,  0);
    add(8'h40, 0, 0, 8'h00, 1, 0, 1, 8'h41, 8'h02, 0,  0);
    add(8'h40, 0, 0, 8'h00, 1, 0, 1, 8'h41, 8'h02, 0,  0);
    add(8'h40, 1, 0, 8'h00, 1, 0, 1, 8'h41, 8'h02, 0,  0);
    add(8'h40, 1, 0, 8'h00, 0, 0, 0, 8'h41, 8'h02, 0,  0);
    add(8'h41, 1, 0, 8'h00, 1, 0, 1, 8'h41, 8'h03, 0,  0);
    add(8'h41, 1, 0, 8'h00, 1, 0, 1, 8'h41, 8'h04, 0,  0);
    add(8'h40, 1, 0, 8'h00, 0, 0, 0, 8'h41, 8'h04, 0,  0);
    add(8'hC1, 1, 0, 8'h00, 0, 1, 1, 8'h41, 8'h05, 0,  0);
    add(8'hC0, 1, 1, 8'h07, 0, 1, 1, 8'h41, 8'h05, 0,  0);
    add(8'hC0, 1, 1, 8'h09, 0, 0, 0, 8'h07, 8'h05, 0,  0);
    add(8'h04, 0, 0, 8'h00, 0, 0, 0, 8'h07, 8'h05, 1,  1);
    add(8'h04, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 2,  1);
    add(8'h04, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 3,  1);
    add(8'h10, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 3,  0);
    add(8'h81, 0, 1, 8'h00, 0, 1, 1, 8'h01, 8'h06, 3,  1);
    add(8'h80, 0, 1, 8'h00, 0, 0, 0, 8'h00, 8'h06, 3,  1);
    add(8'h91, 0, 1, 8'h22, 0, 1, 1, 8'h00, 8'h07, 3,  0);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h22, 8'h07, 3,  0);

    #3;
    check_reset_outputs("reset0");
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    chk("put_transfer_count", 32'(put_xfers), 32'd3);

    // Reset arriving while a GET is still waiting for data.
    @(negedge Clock);
    Command = 8'h81; GetValid = 1'b0; PutReady = 1'b0;
    #4;
    chk("midget_getready_before", 32'(GetReady), 32'h1);
    @(negedge Clock);
    #2;
    Reset_n = 1'b0; Command = 8'h00; GetValid = 1'b1; GetData = 8'h5A;
    #1;
    check_reset_outputs("midget_async");
    @(posedge Clock);
    #1;
    check_reset_outputs("midget_held");
    @(negedge Clock);
    Reset_n = 1'b1; GetValid = 1'b0;
    #1;
    check_reset_outputs("midget_release");
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock);
      Command = 8'h04;
      @(posedge Clock);
      #1;
      chk($sformatf("post_reset_x%0d_dataptr", i), 32'(DataPtr), 32'(i));
      chk($sformatf("post_reset_x%0d_zero", i), 32'(Zero), 32'h1);
      $display("post-reset step %0d x=%0d zero=%0b", i, DataPtr, Zero);
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/potato1_datapath.md
POTATO1_DATAPATH -- requirements
Module: potato1_datapath

Interface
REQ-001 Parameters: PC_W default 8 (program-counter width); TAPE_DEPTH default 16 (data cells); CELL_W default 8 (cell width); X_W = log2(TAPE_DEPTH).
REQ-002 Clock  in  1  rising edge is the only active edge; reset Reset_n, asynchronous, active-low; clock Clock.
REQ-003 Reset_n  in  1  asynchronous active-low reset.
REQ-004 Command  in  8  command word from the core: [0] PC_INC, [1] PC_DEC, [2] X_INC, [3] X_DEC, [4] A_INC, [5] A_DEC, [6] PUT, [7] GET; stable from each falling edge to the next.
REQ-005 ProgAddr  out  PC_W  program counter, addresses the external asynchronous program ROM.
REQ-006 ProgData  in  4  opcode read at ProgAddr.
REQ-007 Instr  out  4  opcode to core input bits [7:4]; equals ProgData, combinational.
REQ-008 Zero  out  1  to core input bit [3]; 1 when tape[X] == 0.
REQ-009 IoBusy  out  1  to core input bit [2]; 1 while a PUT/GET handshake is pending.
REQ-010 DataPtr  out  X_W  current data pointer X.
REQ-011 PutData  out  CELL_W  tape[X]; PutValid out 1; PutReady in 1.
REQ-012 GetData  in  CELL_W; GetValid in 1; GetReady out 1.

Function
REQ-013 All state (PC, X, tape, IoDone) SHALL update only on the rising edge, using the Command value present at that edge; Instr/Zero/IoBusy are seen by the core at the following rising edge (one-cycle loop latency).
REQ-014 fresh = Command[0] | Command[1]; a fresh word marks first issue of an instruction.
REQ-015 PC: PC_INC only -> PC+1; PC_DEC only -> PC-1; both or neither -> hold; wraps modulo 2^PC_W.
REQ-016 X: X_INC only -> X+1; X_DEC only -> X-1; both or neither -> hold; wraps modulo TAPE_DEPTH.
REQ-017 Cell: A_INC only -> tape[X]+1; A_DEC only -> tape[X]-1; both or neither -> hold; wraps modulo 2^CELL_W; A ops address the pre-edge X when an X op occurs in the same word.
REQ-018 PutValid = Command[6] & (fresh | ~IoDone); PutData = tape[X] (pre-edge X).
REQ-019 GetReady = Command[7] & (fresh | ~IoDone); GetValid & GetReady at an edge writes GetData into tape[X], overriding any A op on that cell.
REQ-020 IoBusy = PutValid | GetReady, combinational.
REQ-021 IoDone state: at an edge, a transfer (PutValid&PutReady or GetValid&GetReady) sets IoDone=1; otherwise, fresh clears IoDone=0; otherwise IoDone holds.
REQ-022 PUT and GET both set: GET takes precedence; PutValid forced 0.
REQ-023 Transfer completing on the first (fresh) edge: IoBusy was 1 at that edge; the core waits exactly one cycle; no second transfer occurs for the repeated non-fresh word.
REQ-024 Back-to-back identical PUT instructions SHALL each produce exactly one transfer, because each is issued fresh.
REQ-025 Zero SHALL reflect tape[X] after all updates of the last edge (combinational from state).

Reset
REQ-026 Reset_n low SHALL asynchronously clear PC=0, X=0, every tape cell=0, IoDone=0.
REQ-027 Outputs during reset: ProgAddr=0, DataPtr=0, Zero=1, PutData=0; PutValid/GetReady/IoBusy=0 while Command=0. The core clears Command in the same reset.
REQ-028 Reset during a pending handshake SHALL abandon it; no tape write occurs.

Structure
REQ-029 Shared package potato1_pkg: command bit indices, opcode encodings (0000..0111, 1111 HALT), default widths; also used by the core.
REQ-030 One sub-module, potato1_tape: TAPE_DEPTH x CELL_W registers; inc/dec/write port; zero detect; read port at X.

Verification
REQ-031 Reset, Command=0x01 for 3 edges -> ProgAddr 0,1,2,3; Command=0x02 at PC=0 -> ProgAddr=0xFF.
REQ-032 Command=0x10 x3, then 0x20 x1 -> tape[0]=2, Zero=0; 0x20 at cell 0 -> 0xFF; X_DEC at X=0 -> DataPtr=15.
REQ-033 tape[0]=0x41, Command=0x41 with PutReady=0 for 4 edges (words 0x41, 0x40...) -> PutValid/IoBusy=1 held, PutData=0x41; PutReady=1 -> one transfer, IoBusy=0 next cycle.
REQ-034 Two consecutive fresh PUT words (0x41) with PutReady=1 -> exactly two transfers.
REQ-035 Command=0x81, GetValid=1 with GetData=0x00 at X=3 -> tape[3]=0, Zero=1, GetReady drops after the edge.
REQ-036 Reset_n low mid-GET wait -> PC=X=0, tape unchanged from zero, GetReady=0, no write.
